// File: rtl/muldiv_seq.sv
// Sequential RV32 M-extension unit: 32-cycle shift-add multiply and restoring divide.
// Optional build macro MULDIV_EARLY_OUT_EN sends divide-by-zero and signed overflow straight to FIX.
module muldiv_seq #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      func3,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   input  logic            kill,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t              state_q, state_d;
   logic [2:0]          op_q;
   logic [2*XLEN-1:0]   acc_q;
   logic [XLEN-1:0]     a_q, b_q, fix_q, result_q;
   logic                a_neg_q, b_neg_q, dz_q, ovf_q;
   logic [5:0]          cnt_q;

   logic                is_div_in, sa_in, sb_in, a_neg_in, b_neg_in, dz_in, ovf_in, early_in, accept;
   logic [XLEN-1:0]     a_mag_in, b_mag_in;
   logic [XLEN:0]       mul_sum, div_trial;
   logic [2*XLEN-1:0]   mul_next, div_next, prod;
   logic [XLEN-1:0]     quot, rem_mag, rem, fix_val;

   // Sign interpretation of each operand follows the op group (mul family vs div family)
   assign is_div_in = func3[2];
   assign sa_in     = is_div_in ? ~func3[0] : (func3[1:0] != 2'b11);
   assign sb_in     = is_div_in ? ~func3[0] : ~func3[1];
   assign a_neg_in  = sa_in & rs1[XLEN-1];
   assign b_neg_in  = sb_in & rs2[XLEN-1];
   assign a_mag_in  = a_neg_in ? -rs1 : rs1;
   assign b_mag_in  = b_neg_in ? -rs2 : rs2;
   assign dz_in     = is_div_in & (rs2 == '0);
   assign ovf_in    = is_div_in & ~func3[0] & (rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (rs2 == '1);
   assign accept    = (state_q == IDLE) & start & ~kill;

`ifdef MULDIV_EARLY_OUT_EN
   assign early_in = dz_in | ovf_in;
`else
   assign early_in = 1'b0;
`endif

   // One iteration: multiply adds B into the high half then shifts right; divide shifts left and trial-subtracts
   assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
   assign mul_next  = {mul_sum, acc_q[XLEN-1:1]};
   assign div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_q};
   assign div_next  = div_trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                      : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

   assign prod    = (a_neg_q ^ b_neg_q) ? -acc_q : acc_q;
   assign quot    = dz_q  ? '1 :
                    ovf_q ? {1'b1, {(XLEN-1){1'b0}}} :
                    (a_neg_q ^ b_neg_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
   assign rem_mag = dz_q ? a_q : acc_q[2*XLEN-1:XLEN];
   assign rem     = ovf_q ? '0 : (a_neg_q ? -rem_mag : rem_mag);

   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch can be inferred
      fix_val = quot;
      case (op_q)
         3'b000:                 fix_val = prod[XLEN-1:0];
         3'b001, 3'b010, 3'b011: fix_val = prod[2*XLEN-1:XLEN];
         3'b110, 3'b111:         fix_val = rem;
         default:                fix_val = quot;
      endcase
   end

   always_comb begin
      state_d = state_q;
      busy    = (state_q != IDLE);
      done    = 1'b0;
      case (state_q)
         IDLE: if (accept) state_d = early_in ? FIX : CALC;
         CALC: if (cnt_q == 6'(XLEN-1)) state_d = FIX;
         FIX:  state_d = DONE;
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // kill outranks both start and the DONE pulse
      if (kill && state_q != IDLE) begin
         state_d = IDLE;
         done    = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q     <= '0;
         acc_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         a_neg_q  <= 1'b0;
         b_neg_q  <= 1'b0;
         dz_q     <= 1'b0;
         ovf_q    <= 1'b0;
         cnt_q    <= '0;
         fix_q    <= '0;
         result_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values
         case (state_q)
            IDLE: if (accept) begin
               op_q    <= func3;
               a_q     <= a_mag_in;
               b_q     <= b_mag_in;
               acc_q   <= {{XLEN{1'b0}}, a_mag_in};
               a_neg_q <= a_neg_in;
               b_neg_q <= b_neg_in;
               dz_q    <= dz_in;
               ovf_q   <= ovf_in;
               cnt_q   <= '0;
            end
            CALC: begin
               cnt_q <= cnt_q + 6'd1;
               acc_q <= op_q[2] ? div_next : mul_next;
            end
            FIX:  fix_q <= fix_val;
            DONE: if (!kill) result_q <= fix_q;
            default: ;
         endcase
      end
   end

   // Result shows the fresh value during the done cycle and is held in result_q afterwards
   assign result = done ? fix_q : result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq: results, latency, kill, reset and start filtering.
module tb_muldiv_seq;

   localparam int EO_LAT =
`ifdef MULDIV_EARLY_OUT_EN
      2;
`else
      34;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        kill = 1'b0;
   logic [2:0]  func3 = '0;
   logic [31:0] rs1 = '0;
   logic [31:0] rs2 = '0;
   logic        busy, done;
   logic [31:0] result;

   int n_cmp = 0;
   int n_bad = 0;

   muldiv_seq #(.XLEN(32)) dut (
      .clk(clk), .rst(rst), .start(start), .func3(func3), .rs1(rs1), .rs2(rs2),
      .kill(kill), .busy(busy), .done(done), .result(result)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   typedef struct packed {
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] e;
      logic        eo;
   } vec_t;

   localparam vec_t VECS [18] = '{
      '{3'd0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0},
      '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0},
      '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0},
      '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0},
      '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0},
      '{3'd0, 32'h12345678, 32'h00000010, 32'h23456780, 1'b0},
      '{3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0},
      '{3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0},
      '{3'd4, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0},
      '{3'd6, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 1'b0},
      '{3'd5, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0},
      '{3'd5, 32'h00000064, 32'h00000007, 32'h0000000E, 1'b0},
      '{3'd7, 32'h00000064, 32'h00000007, 32'h00000002, 1'b0},
      '{3'd5, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1'b1},
      '{3'd7, 32'h00000005, 32'h00000000, 32'h00000005, 1'b1},
      '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1},
      '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1},
      '{3'd6, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 1'b1}
   };

   // Called at a negedge; start is sampled at the following posedge (edge N).
   // poke > 0 raises start with other operands at that cycle to prove it is ignored while busy.
   task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input int poke);
      int n;
      logic seen;
      func3 = f; rs1 = a; rs2 = b; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 60) begin
         @(negedge clk);
         n++;
         if (n == 1) check({tag, "_busy"}, 64'(busy), 64'd1);
         seen = done;
         if (n == poke) begin
            func3 = 3'd0; rs1 = 32'd3; rs2 = 32'd3; start = 1'b1;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      check({tag, "_lat"}, 64'(n), 64'(lat));
      check(tag, 64'(result), 64'(exp));
      @(negedge clk);
      check({tag, "_pulse"}, {62'd0, busy, done}, 64'd0);
      check({tag, "_hold"}, 64'(result), 64'(exp));
   endtask

   task automatic no_done_for(input string tag, input int cycles);
      int hits;
      hits = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (done) hits++;
      end
      check(tag, 64'(hits), 64'd0);
   endtask

   initial begin
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_result", 64'(result), 64'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Directed vectors back to back: each start lands in the cycle busy falls
      for (int i = 0; i < 18; i++)
         run_op($sformatf("v%0d", i), VECS[i].f, VECS[i].a, VECS[i].b, VECS[i].e,
                VECS[i].eo ? EO_LAT : 34, 0);

      // Kill in the middle of a divide
      run_op("pre_kill", 3'd5, 32'd100, 32'd7, 32'h0000000E, 34, 0);
      func3 = 3'd4; rs1 = 32'd1000; rs2 = 32'd3; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (9) @(posedge clk);
      #1 kill = 1'b1;
      @(posedge clk); #1 kill = 1'b0;
      @(negedge clk);
      check("kill_busy", 64'(busy), 64'd0);
      check("kill_result", 64'(result), 64'h0000000E);
      no_done_for("kill_nodone", 40);
      run_op("post_kill", 3'd4, 32'd1000, 32'd3, 32'd333, 34, 0);

      // start and kill together in IDLE do nothing
      func3 = 3'd0; rs1 = 32'd9; rs2 = 32'd9; start = 1'b1; kill = 1'b1;
      @(posedge clk); #1 start = 1'b0; kill = 1'b0;
      @(negedge clk);
      check("startkill_busy", 64'(busy), 64'd0);
      no_done_for("startkill_nodone", 40);

      // start while busy is ignored
      run_op("ign_start", 3'd7, 32'd100, 32'd7, 32'd2, 34, 5);

      // Asynchronous reset mid-operation
      func3 = 3'd0; rs1 = 32'd7; rs2 = 32'hFFFFFFFD; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (19) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_done", 64'(done), 64'd0);
      check("midrst_result", 64'(result), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      no_done_for("midrst_nodone", 40);
      run_op("post_rst", 3'd0, 32'd6, 32'd7, 32'd42, 34, 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
